acc_datapath: RTL

- Register-transfer datapath directly downstream of the microprogrammed control unit. It consumes the 32-bit Control_Signals word each cycle and executes the selected transfers: MAR, MBR, PC, IR, BR, ACC and the ALU.
- It drives the single-port main memory.
- It returns IR_out and the ALU flag nibble {ZF,CF,OF,SF} to the control unit, closing the fetch/decode/execute loop.

---
 rtl/acc_datapath.sv | 136 +++++++++++++
 1 files changed

// File: rtl/acc_datapath.sv
// Accumulator-machine datapath: MAR/MBR/PC/IR/BR/ACC plus ALU, driven one micro-op word per cycle.
// Each register loads on the edge after its control bit; conflicting or unimplemented micro-ops raise a sticky ctrl_err.
module acc_datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Control_Signals,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] IR_out,
    output logic [3:0]        ALUflags,
    output logic [ADDR_W-1:0] PC_out,
    output logic [DATA_W-1:0] ACC_out,
    output logic              ctrl_err
);

    localparam int SHW = $clog2(DATA_W + 1);

    logic [ADDR_W-1:0] mar, pc;
    logic [DATA_W-1:0] mbr, ir, br, acc;
    logic [3:0]        flags;
    logic              err;

    logic [31:0] c;
    assign c = Control_Signals;

    logic [7:0] alu_sel;
    logic       alu_multi;
    logic       conflict;
    assign alu_sel   = {c[21], c[20], c[19], c[18], c[17], c[15], c[13], c[9]};
    assign alu_multi = (alu_sel & (alu_sel - 8'd1)) != 8'd0;
    assign conflict  = (c[3] & c[12]) | (c[5] & c[10]) | (c[6] & c[14]) | alu_multi | c[16];

    logic unused_ctrl;
    assign unused_ctrl = ^{c[31:22], c[2:0]};

    logic [DATA_W-1:0]          res;
    logic                       cf, of, alu_go;
    logic signed [DATA_W:0]     sum_s;
    logic [2*DATA_W-1:0]        prod;
    logic [DATA_W:0]            shl_ext, shr_ext;

    // Lowest-indexed ALU op wins; all operands are pre-edge register values.
    always_comb begin
        res     = acc;
        cf      = 1'b0;
        of      = 1'b0;
        alu_go  = 1'b1;
        sum_s   = '0;
        prod    = '0;
        shl_ext = '0;
        shr_ext = '0;
        if (c[9]) begin
            {cf, res} = {1'b0, acc} + {1'b0, br};
            sum_s     = $signed({acc[DATA_W-1], acc}) + $signed({br[DATA_W-1], br});
            of        = sum_s[DATA_W] != sum_s[DATA_W-1];
        end else if (c[13]) begin
            {cf, res} = {1'b0, acc} - {1'b0, br};
            sum_s     = $signed({acc[DATA_W-1], acc}) - $signed({br[DATA_W-1], br});
            of        = sum_s[DATA_W] != sum_s[DATA_W-1];
        end else if (c[15]) begin
            prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, br};
            res  = prod[DATA_W-1:0];
            cf   = |prod[2*DATA_W-1:DATA_W];
            of   = cf;
        end else if (c[17]) begin
            if (32'(br) > 32'(DATA_W)) begin
                res = '0;
            end else begin
                shl_ext = {1'b0, acc} << br[SHW-1:0];
                res     = shl_ext[DATA_W-1:0];
                cf      = shl_ext[DATA_W];
            end
        end else if (c[18]) begin
            if (32'(br) > 32'(DATA_W)) begin
                res = '0;
            end else begin
                shr_ext = {acc, 1'b0} >> br[SHW-1:0];
                res     = shr_ext[DATA_W:1];
                cf      = shr_ext[0];
            end
        end else if (c[19]) begin
            res = acc & br;
        end else if (c[20]) begin
            res = acc | br;
        end else if (c[21]) begin
            res = ~br;
        end else begin
            alu_go = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar   <= '0;
            mbr   <= '0;
            pc    <= '0;
            ir    <= '0;
            br    <= '0;
            acc   <= '0;
            flags <= 4'b0000;
            err   <= 1'b0;
        end else begin
            if (c[12])      mbr <= acc;
            else if (c[3])  mbr <= mem_rdata;
            if (c[4])       ir  <= mbr;
            if (c[7])       br  <= mbr;
            if (c[10])      mar <= pc;
            else if (c[5])  mar <= mbr[ADDR_W-1:0];
            if (c[14])      pc  <= mbr[ADDR_W-1:0];
            else if (c[6])  pc  <= pc + ADDR_W'(1);
            if (c[8]) begin
                acc <= '0;
            end else if (alu_go) begin
                acc   <= res;
                flags <= {res == '0, cf, of, res[DATA_W-1]};
            end
            if (conflict)   err <= 1'b1;
        end
    end

    // Write strobe is gated by rst_n so no write can escape while reset is asserted.
    assign mem_we    = rst_n & c[11] & ~c[3];
    assign mem_addr  = mar;
    assign mem_wdata = mbr;
    assign IR_out    = ir;
    assign ALUflags  = flags;
    assign PC_out    = pc;
    assign ACC_out   = acc;
    assign ctrl_err  = err;

endmodule
